// File: rtl/msd_pkg.sv
// msd_pkg: shared definitions for the Moore sequence detector.
// Holds the prefix-fallback next-state function, the state width helper
// and the default match counter type.
// Optional feature macro used by the top: MSD_MATCH_COUNT_EN.
package msd_pkg;

   // Widest pattern the fallback function is written to handle.
   localparam int MSD_MAX_LEN = 16;

   // Default match counter width and its type.
   localparam int MSD_COUNT_W_DEFAULT = 8;
   typedef logic [MSD_COUNT_W_DEFAULT-1:0] msd_count_t;

   // Number of bits needed to hold a prefix length 0..len.
   function automatic int msd_state_width(input int len);
      return $clog2(len + 1);
   endfunction

   // Next prefix length after accepting bit b from prefix length k.
   // The received history is reconstructed from the pattern itself (the first
   // k pattern bits followed by b); the result is the longest suffix of that
   // history, no longer than len, that is also a prefix of the pattern.
   // Leaving a full match with overlap=0 starts over from an empty history.
   function automatic int msd_next_state(input int k,
                                         input logic b,
                                         input logic overlap,
                                         input logic [MSD_MAX_LEN-1:0] pattern,
                                         input int len);
      int               kk;
      int               lim;
      int               best;
      int               pos;
      logic             ok;
      logic [MSD_MAX_LEN:0] hist;

      kk = ((k >= len) && !overlap) ? 0 : k;

      // hist[0] is the newest bit, hist[i] (i>=1) the matched prefix bits
      hist = '0;
      hist[0] = b;
      for (int i = 1; i <= MSD_MAX_LEN; i++) begin
         if (i <= kk) begin
            pos = len - kk - 1 + i;
            hist[i] = pattern[pos[3:0]];
         end
      end

      lim  = (kk + 1 < len) ? kk + 1 : len;
      best = 0;
      for (int j = 1; j <= MSD_MAX_LEN; j++) begin
         if (j <= lim) begin
            ok = 1'b1;
            for (int i = 0; i < MSD_MAX_LEN; i++) begin
               if (i < j) begin
                  pos = len - j + i;
                  if (hist[i] != pattern[pos[3:0]]) ok = 1'b0;
               end
            end
            if (ok) best = j;
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/msd_sat_counter.sv
// msd_sat_counter: saturating up-counter with synchronous clear.
// Used by moore_seq_detector only when MSD_MATCH_COUNT_EN is defined.
module msd_sat_counter
   import msd_pkg::*;
#(
   parameter int COUNT_W = MSD_COUNT_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   input  logic               clr,
   output logic [COUNT_W-1:0] count
);

   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   logic [COUNT_W-1:0] count_reg;

   // Count up on inc, stick at all-ones, clear wins over inc.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != COUNT_MAX)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/moore_seq_detector.sv
// moore_seq_detector: Moore detector for a LEN-bit serial pattern.
// State is the length of the longest pattern prefix matched so far; a miss
// falls back to the longest still-valid prefix rather than to zero.
// Optional feature: define MSD_MATCH_COUNT_EN to add the saturating
// match_count output.
module moore_seq_detector
   import msd_pkg::*;
#(
   parameter int             LEN     = 4,
   parameter logic [LEN-1:0] PATTERN = 4'b1101,
   parameter int             COUNT_W = 8,
   localparam int            SW      = msd_state_width(LEN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          in_bit,
   input  logic          mode_overlap,
   input  logic          clear,
   output logic [SW-1:0] state,
   output logic          match
`ifdef MSD_MATCH_COUNT_EN
   ,
   output logic [COUNT_W-1:0] match_count
`endif
);

   localparam logic [MSD_MAX_LEN-1:0] PAT_EXT   = MSD_MAX_LEN'(PATTERN);
   localparam logic [SW-1:0]          STATE_FULL = SW'(LEN);

   logic [SW-1:0] state_reg;
   logic [SW-1:0] state_next;

   // Prefix fallback for the bit on in_bit; only used when in_valid is high,
   // so an undefined in_bit during a stall never reaches the register.
   always_comb begin
      state_next = SW'(msd_next_state(int'(state_reg), in_bit, mode_overlap,
                                      PAT_EXT, LEN));
   end

   // State register: reset, then clear, then accept a qualified bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= '0;
      end else if (clear) begin
         state_reg <= '0;
      end else if (in_valid) begin
         state_reg <= state_next;
      end
   end

   assign state = state_reg;
   assign match = (state_reg == STATE_FULL);

`ifdef MSD_MATCH_COUNT_EN
   logic count_inc;

   // A match is counted on the edge that enters (or re-enters) the full state.
   always_comb begin
      count_inc = in_valid && !clear && (state_next == STATE_FULL);
   end

   msd_sat_counter #(
      .COUNT_W (COUNT_W)
   ) u_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (count_inc),
      .clr   (clear),
      .count (match_count)
   );
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Testbench for moore_seq_detector (LEN=4 pattern 1101 and LEN=1 pattern 1).
// Build with MSD_MATCH_COUNT_EN defined to also check match_count.
module tb_moore_seq_detector;

   localparam int             LEN  = 4;
   localparam logic [LEN-1:0] PAT  = 4'b1101;
   localparam int             CW   = 8;
   localparam int             CMAX = (1 << CW) - 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_bit, mode_overlap, clear;
   logic [2:0] state;
   logic       match;
   logic       in_valid1, in_bit1, mode_overlap1, clear1;
   logic [0:0] state1;
   logic       match1;
`ifdef MSD_MATCH_COUNT_EN
   logic [CW-1:0] match_count;
   logic [1:0]    match_count1;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      string tag;
      int    st;
      int    m;
      int    cnt;
   } exp_t;
   exp_t sbq[$];

   // reference model: raw bit history since last restart
   logic hist[$];
   int   m_state = 0;
   int   m_cnt   = 0;
   logic [LEN-1:0] pat_v;

   always #5 clk = ~clk;

   moore_seq_detector #(.LEN(LEN), .PATTERN(PAT), .COUNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
      .mode_overlap(mode_overlap), .clear(clear), .state(state), .match(match)
`ifdef MSD_MATCH_COUNT_EN
      , .match_count(match_count)
`endif
   );

   moore_seq_detector #(.LEN(1), .PATTERN(1'b1), .COUNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_bit(in_bit1),
      .mode_overlap(mode_overlap1), .clear(clear1), .state(state1), .match(match1)
`ifdef MSD_MATCH_COUNT_EN
      , .match_count(match_count1)
`endif
   );

   task automatic check(input string tag, input int obs, input int exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // longest suffix of the history (<= LEN) equal to a pattern prefix
   function automatic int longest_prefix();
      int  n;
      int  lim;
      bit  ok;
      n   = hist.size();
      lim = (n < LEN) ? n : LEN;
      for (int j = lim; j >= 1; j--) begin
         ok = 1'b1;
         for (int i = 0; i < j; i++)
            if (hist[n-j+i] !== pat_v[LEN-1-i]) ok = 1'b0;
         if (ok) return j;
      end
      return 0;
   endfunction

   task automatic model_step(input logic v, input logic b, input logic ov, input logic clr);
      if (clr) begin
         hist.delete();
         m_state = 0;
         m_cnt   = 0;
      end else if (v) begin
         if (m_state == LEN && !ov) hist.delete();
         hist.push_back(b);
         if (hist.size() > LEN) void'(hist.pop_front());
         m_state = longest_prefix();
         if (m_state == LEN && m_cnt < CMAX) m_cnt++;
      end
   endtask

   task automatic step(input logic v, input logic b, input logic ov, input logic clr,
                       input string tag);
      exp_t e;
      @(negedge clk);
      in_valid = v; in_bit = b; mode_overlap = ov; clear = clr;
      model_step(v, b, ov, clr);
      e.tag = tag; e.st = m_state; e.m = (m_state == LEN) ? 1 : 0; e.cnt = m_cnt;
      sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      $display("[TB] %s v=%0d b=%0d ov=%0d clr=%0d state=%0d match=%0d", e.tag, v, b, ov,
               clr, state, match);
      check({e.tag, "/state"}, int'(state), e.st);
      check({e.tag, "/match"}, int'(match), e.m);
`ifdef MSD_MATCH_COUNT_EN
      check({e.tag, "/count"}, int'(match_count), e.cnt);
`endif
   endtask

   task automatic step1(input logic v, input logic b, input logic clr,
                        input int exp_st, input int exp_cnt, input string tag);
      exp_t e;
      @(negedge clk);
      in_valid1 = v; in_bit1 = b; clear1 = clr;
      e.tag = tag; e.st = exp_st; e.m = exp_st; e.cnt = exp_cnt;
      sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      $display("[TB] %s v=%0d b=%0d clr=%0d state=%0d match=%0d", e.tag, v, b, clr,
               state1, match1);
      check({e.tag, "/state"}, int'(state1), e.st);
      check({e.tag, "/match"}, int'(match1), e.m);
`ifdef MSD_MATCH_COUNT_EN
      check({e.tag, "/count"}, int'(match_count1), e.cnt);
`else
      if (exp_cnt < 0) $display("[TB] unexpected negative count");
`endif
   endtask

   initial begin
      pat_v = PAT;
      rst = 1'b1;
      in_valid = 0; in_bit = 0; mode_overlap = 1; clear = 0;
      in_valid1 = 0; in_bit1 = 0; mode_overlap1 = 1; clear1 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset/state", int'(state), 0);
      check("reset/match", int'(match), 0);
`ifdef MSD_MATCH_COUNT_EN
      check("reset/count", int'(match_count), 0);
`endif
      @(negedge clk) rst = 1'b0;

      // 1: async reset mid-cycle while state=3
      step(1, 1, 1, 0, "t1_b1");
      step(1, 1, 1, 0, "t1_b2");
      step(1, 0, 1, 0, "t1_b3");
      check("t1_pre_rst_state", int'(state), 3);
      #2 rst = 1'b1;
      #1;
      check("t1_async_state", int'(state), 0);
      check("t1_async_match", int'(match), 0);
      in_valid = 1; in_bit = 1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("t1_hold_state", int'(state), 0);
      end
      @(negedge clk) rst = 1'b0; in_valid = 0;
      hist.delete(); m_state = 0; m_cnt = 0;

      // 2: overlapping 1101101
      step(0, 0, 1, 1, "t2_clr");
      step(1, 1, 1, 0, "t2_b1");
      step(1, 1, 1, 0, "t2_b2");
      step(1, 0, 1, 0, "t2_b3");
      step(1, 1, 1, 0, "t2_b4");
      check("t2_match_b4", int'(match), 1);
      step(1, 1, 1, 0, "t2_b5");
      step(1, 0, 1, 0, "t2_b6");
      step(1, 1, 1, 0, "t2_b7");
      check("t2_match_b7", int'(match), 1);
`ifdef MSD_MATCH_COUNT_EN
      check("t2_count_end", int'(match_count), 2);
`endif

      // 3: non-overlapping 1101101
      step(0, 0, 0, 1, "t3_clr");
      step(1, 1, 0, 0, "t3_b1");
      step(1, 1, 0, 0, "t3_b2");
      step(1, 0, 0, 0, "t3_b3");
      step(1, 1, 0, 0, "t3_b4");
      step(1, 1, 0, 0, "t3_b5");
      step(1, 0, 0, 0, "t3_b6");
      step(1, 1, 0, 0, "t3_b7");
      check("t3_state_b7", int'(state), 1);
`ifdef MSD_MATCH_COUNT_EN
      check("t3_count_end", int'(match_count), 1);
`endif

      // 4: fallback on 11101
      step(0, 0, 1, 1, "t4_clr");
      step(1, 1, 1, 0, "t4_b1");
      step(1, 1, 1, 0, "t4_b2");
      step(1, 1, 1, 0, "t4_b3");
      check("t4_state_b3", int'(state), 2);
      step(1, 0, 1, 0, "t4_b4");
      step(1, 1, 1, 0, "t4_b5");
      check("t4_state_b5", int'(state), 4);

      // 5: stall with toggling in_bit (and X) between bits 3 and 4
      step(0, 0, 1, 1, "t5_clr");
      step(1, 1, 1, 0, "t5_b1");
      step(1, 1, 1, 0, "t5_b2");
      step(1, 0, 1, 0, "t5_b3");
      step(0, 1, 0, 0, "t5_stall1");
      step(0, 0, 0, 0, "t5_stall2");
      step(0, 1'bx, 1, 0, "t5_stall3");
      check("t5_state_stall", int'(state), 3);
      step(1, 1, 1, 0, "t5_b4");
      step(0, 0, 0, 0, "t5_hold_match");
      check("t5_match_held", int'(match), 1);

      // 6: LEN=1 counter saturation, then clear beats a valid bit
      step1(1, 1, 0, 1, 1, "t6_b1");
      step1(1, 1, 0, 1, 2, "t6_b2");
      step1(1, 1, 0, 1, 3, "t6_b3");
      step1(1, 1, 0, 1, 3, "t6_b4");
      step1(1, 1, 0, 1, 3, "t6_b5");
      step1(1, 1, 1, 0, 0, "t6_clear");
      step1(1, 0, 0, 0, 0, "t6_zero");
      step1(1, 1, 0, 1, 1, "t6_one");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
